rv_decode_stage: RTL and testbench
==================================

// Module: rv_decode_stage
// PURPOSE
//  Parametrised RV32/RV64 integer decode pipeline stage between fetch and execute.
//  Decodes OP, OP-IMM, OP-32 and OP-IMM-32 into an encoded ALU op, register addresses and a sign-extended immediate.
//  Flags illegal encodings and counts them.
//  Single-entry registered output with valid/ready handshake and flush.
// PARAMETERS
//  XLEN    64  datapath width, 32 or 64; at 32, OP-32/OP-IMM-32 decode as illegal
//  EN_IMM  1   1 = decode OP-IMM/OP-IMM-32; 0 = treat them as illegal
//  CNT_W   16  width of the illegal-instruction counter
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      synchronous reset, active high
//  in_valid       in   1      in_instr valid
//  in_ready       out  1      stage can accept
//  in_instr       in   32     raw instruction
//  flush          in   1      discard held/incoming instruction
//  out_valid      out  1      decoded bundle valid
//  out_ready      in   1      execute consumes bundle
//  out_rs1_addr   out  5      instr[19:15]
//  out_rs2_addr   out  5      instr[24:20]; 0 when out_use_imm
//  out_rd_addr    out  5      instr[11:7]
//  out_alu_op     out  4      ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9
//  out_word       out  1      32-bit op (W form), result sign-extended by execute
//  out_use_imm    out  1      operand B is out_imm
//  out_imm        out  XLEN   sign-extended instr[31:20]; 0 for register ops
//  out_rd_we      out  1      write rd (0 if illegal or rd==0)
//  out_illegal    out  1      unsupported/illegal encoding
//  illegal_cnt    out  CNT_W  saturating count of accepted illegal instructions
// BEHAVIOUR
//  - Reset (rst=1 at posedge): every output register is 0, including out_valid and illegal_cnt.
//    in_ready=1 the cycle after reset.
//  - in_ready = !out_valid | out_ready (combinational). Accept = in_valid & in_ready & !flush.
//  - Latency 1: an instruction accepted at edge N is presented with out_valid=1 after edge N.
//    Back-to-back accepts sustain 1 instr/cycle.
//  - Stall: out_valid & !out_ready -> all out_* hold stable; no accept.
//  - Consume without new accept -> out_valid=0 next cycle; other out_* may hold stale values.
//  - flush=1: out_valid=0 next cycle; any same-cycle input is dropped. Flush wins over accept.
//    illegal_cnt is not touched by a dropped input.
//  - Legal decode, opcode/funct7/funct3:
//    - OP 0110011, f7=0000000: f3 0..7 -> ADD SLL SLT SLTU XOR SRL OR AND.
//    - OP 0110011, f7=0100000: f3 000 -> SUB, f3 101 -> SRA.
//    - OP-32 0111011 (XLEN=64), out_word=1: f7=0 f3 000/001/101 -> ADD/SLL/SRL;
//      f7=0100000 f3 000/101 -> SUB/SRA.
//    - OP-IMM 0010011 (EN_IMM): f3 as OP, no SUB.
//      f3=001 needs instr[31:26]=0 (XLEN=64) or instr[31:25]=0 (XLEN=32).
//      f3=101: instr[31:26]=000000 -> SRL, =010000 -> SRA; XLEN=32 also needs instr[25]=0.
//    - OP-IMM-32 0011011 (XLEN=64, EN_IMM), out_word=1: f3 000 -> ADD;
//      001 -> SLL with f7=0; 101 -> SRL with f7=0, SRA with f7=0100000.
//  - Any other encoding: out_illegal=1, out_alu_op=ADD, out_rd_we=0, out_use_imm=0, out_imm=0.
//  - illegal_cnt increments on each accepted illegal instruction and saturates at all-ones; it is not affected by flush.
//  - Immediate: {{(XLEN-12){instr[31]}}, instr[31:20]}; shift ops pass it unmodified, execute masks shamt.
//  - rd==0 on a legal op: out_illegal=0, out_rd_we=0.
// TESTING
//  - add x3,x1,x2 (0x002081B3) -> next cycle out_valid=1, alu_op=0, rs1=1 rs2=2 rd=3, rd_we=1, use_imm=0.
//  - sub 0x402081B3 then subw 0x402081BB (XLEN=64) -> alu_op=1 both, word=0 then 1.
//    XLEN=32: subw gives illegal=1, illegal_cnt=1.
//  - addi x5,x0,-1 (0xFFF00293) -> use_imm=1, imm=all-ones (XLEN bits), rs2=0, rd_we=1.
//  - Stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable.
//    Release -> next instr appears next cycle, none lost or duplicated.
//  - flush with in_valid=1 and held bundle -> out_valid=0 next cycle, dropped instr never appears.
//  - 0xFFFFFFFF fed 2^CNT_W+2 times -> illegal_cnt saturates at all-ones; rst mid-stream -> all outputs 0.

Source files
------------

// File: rtl/rv_decode_stage.sv
// RV32/RV64 integer decode stage for OP, OP-IMM, OP-32 and OP-IMM-32 with a
// single registered output slot, valid/ready handshake, flush and an illegal-instruction counter.
module rv_decode_stage #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned EN_IMM = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_rs1_addr,
  output logic [4:0]       out_rs2_addr,
  output logic [4:0]       out_rd_addr,
  output logic [3:0]       out_alu_op,
  output logic             out_word,
  output logic             out_use_imm,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_rd_we,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int unsigned IMM_W  = 12;
  localparam bit          IS_64  = (XLEN == 64);
  localparam bit          HAS_IMM = (EN_IMM != 0);

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] F7_ZERO     = 7'b0000000;
  localparam logic [6:0] F7_ALT      = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [5:0] sh_hi6;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign sh_hi6 = in_instr[31:26];

  // Combinational decode of the incoming instruction
  logic            dec_legal;
  logic            dec_imm_op;
  alu_op_e         dec_alu;
  logic            dec_word;
  alu_op_e         dec_alu_c;
  logic            dec_word_c;
  logic            dec_use_imm_c;
  logic [XLEN-1:0] dec_imm_c;
  logic [4:0]      dec_rs2_c;
  logic            dec_rd_we_c;

  always_comb begin
    dec_legal  = 1'b0;
    dec_imm_op = 1'b0;
    dec_alu    = ALU_ADD;
    dec_word   = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_ZERO) begin
          dec_legal = 1'b1;
          case (funct3)
            3'b000:  dec_alu = ALU_ADD;
            3'b001:  dec_alu = ALU_SLL;
            3'b010:  dec_alu = ALU_SLT;
            3'b011:  dec_alu = ALU_SLTU;
            3'b100:  dec_alu = ALU_XOR;
            3'b101:  dec_alu = ALU_SRL;
            3'b110:  dec_alu = ALU_OR;
            default: dec_alu = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            dec_legal = 1'b1;
            dec_alu   = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            dec_legal = 1'b1;
            dec_alu   = ALU_SRA;
          end
        end
      end
      OPC_OP32: begin
        if (IS_64) begin
          dec_word = 1'b1;
          if (funct7 == F7_ZERO) begin
            if (funct3 == 3'b000) begin
              dec_legal = 1'b1;
              dec_alu   = ALU_ADD;
            end else if (funct3 == 3'b001) begin
              dec_legal = 1'b1;
              dec_alu   = ALU_SLL;
            end else if (funct3 == 3'b101) begin
              dec_legal = 1'b1;
              dec_alu   = ALU_SRL;
            end
          end else if (funct7 == F7_ALT) begin
            if (funct3 == 3'b000) begin
              dec_legal = 1'b1;
              dec_alu   = ALU_SUB;
            end else if (funct3 == 3'b101) begin
              dec_legal = 1'b1;
              dec_alu   = ALU_SRA;
            end
          end
        end
      end
      OPC_OPIMM: begin
        if (HAS_IMM) begin
          dec_imm_op = 1'b1;
          case (funct3)
            3'b000: begin dec_legal = 1'b1; dec_alu = ALU_ADD;  end
            3'b010: begin dec_legal = 1'b1; dec_alu = ALU_SLT;  end
            3'b011: begin dec_legal = 1'b1; dec_alu = ALU_SLTU; end
            3'b100: begin dec_legal = 1'b1; dec_alu = ALU_XOR;  end
            3'b110: begin dec_legal = 1'b1; dec_alu = ALU_OR;   end
            3'b111: begin dec_legal = 1'b1; dec_alu = ALU_AND;  end
            3'b001: begin
              // RV32 shamt is 5 bits, so bit 25 must be clear there
              if (sh_hi6 == 6'b000000 && (IS_64 || !in_instr[25])) begin
                dec_legal = 1'b1;
                dec_alu   = ALU_SLL;
              end
            end
            default: begin
              if (IS_64 || !in_instr[25]) begin
                if (sh_hi6 == 6'b000000) begin
                  dec_legal = 1'b1;
                  dec_alu   = ALU_SRL;
                end else if (sh_hi6 == 6'b010000) begin
                  dec_legal = 1'b1;
                  dec_alu   = ALU_SRA;
                end
              end
            end
          endcase
        end
      end
      OPC_OPIMM32: begin
        if (IS_64 && HAS_IMM) begin
          dec_imm_op = 1'b1;
          dec_word   = 1'b1;
          if (funct3 == 3'b000) begin
            dec_legal = 1'b1;
            dec_alu   = ALU_ADD;
          end else if (funct3 == 3'b001 && funct7 == F7_ZERO) begin
            dec_legal = 1'b1;
            dec_alu   = ALU_SLL;
          end else if (funct3 == 3'b101 && funct7 == F7_ZERO) begin
            dec_legal = 1'b1;
            dec_alu   = ALU_SRL;
          end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
            dec_legal = 1'b1;
            dec_alu   = ALU_SRA;
          end
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Illegal encodings collapse to a harmless non-writing ADD
  always_comb begin
    dec_alu_c     = dec_legal ? dec_alu : ALU_ADD;
    dec_word_c    = dec_legal & dec_word;
    dec_use_imm_c = dec_legal & dec_imm_op;
    dec_imm_c     = '0;
    if (dec_use_imm_c) begin
      dec_imm_c = {{(XLEN-IMM_W){in_instr[31]}}, in_instr[31:20]};
    end
    dec_rs2_c     = dec_use_imm_c ? 5'd0 : in_instr[24:20];
    dec_rd_we_c   = dec_legal & (in_instr[11:7] != 5'd0);
  end

  logic accept;
  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready & !flush;

  logic             valid_d, valid_q;
  logic [4:0]       rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [3:0]       alu_d, alu_q;
  logic             word_d, word_q, use_imm_d, use_imm_q;
  logic [XLEN-1:0]  imm_d, imm_q;
  logic             rd_we_d, rd_we_q, illegal_d, illegal_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next-state for the output slot and the saturating counter
  always_comb begin
    valid_d   = valid_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    alu_d     = alu_q;
    word_d    = word_q;
    use_imm_d = use_imm_q;
    imm_d     = imm_q;
    rd_we_d   = rd_we_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      rs1_d     = in_instr[19:15];
      rs2_d     = dec_rs2_c;
      rd_d      = in_instr[11:7];
      alu_d     = dec_alu_c;
      word_d    = dec_word_c;
      use_imm_d = dec_use_imm_c;
      imm_d     = dec_imm_c;
      rd_we_d   = dec_rd_we_c;
      illegal_d = !dec_legal;
      if (!dec_legal && cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      alu_q     <= '0;
      word_q    <= 1'b0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      rd_we_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      alu_q     <= alu_d;
      word_q    <= word_d;
      use_imm_q <= use_imm_d;
      imm_q     <= imm_d;
      rd_we_q   <= rd_we_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_rs1_addr = rs1_q;
  assign out_rs2_addr = rs2_q;
  assign out_rd_addr  = rd_q;
  assign out_alu_op   = alu_q;
  assign out_word     = word_q;
  assign out_use_imm  = use_imm_q;
  assign out_imm      = imm_q;
  assign out_rd_we    = rd_we_q;
  assign out_illegal  = illegal_q;
  assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage (RV64, immediates on, 8-bit counter):
// expected bundles are queued on accept and compared while the DUT presents them.
module tb_rv_decode_stage;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu;
    logic            word;
    logic            use_imm;
    logic [XLEN-1:0] imm;
    logic            rd_we;
    logic            illegal;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic [3:0]       out_alu_op;
  logic             out_word, out_use_imm, out_rd_we, out_illegal;
  logic [XLEN-1:0]  out_imm;
  logic [CNT_W-1:0] illegal_cnt;

  rv_decode_stage #(.XLEN(XLEN), .EN_IMM(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
    .out_alu_op(out_alu_op), .out_word(out_word), .out_use_imm(out_use_imm),
    .out_imm(out_imm), .out_rd_we(out_rd_we), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  exp_t got;
  assign got = {out_rs1_addr, out_rs2_addr, out_rd_addr, out_alu_op, out_word,
                out_use_imm, out_imm, out_rd_we, out_illegal};

  int unsigned      n_tests = 0;
  int unsigned      n_fail  = 0;
  exp_t             sb[$];
  logic             m_valid = 1'b0;
  logic [CNT_W-1:0] m_cnt   = '0;

  localparam logic [6:0] OP = 7'b0110011, OP32 = 7'b0111011;
  localparam logic [6:0] OPI = 7'b0010011, OPI32 = 7'b0011011;
  localparam logic [31:0] ILL = 32'hFFFF_FFFF;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic exp_t mk(input logic [31:0] ins, input logic [3:0] alu,
      input logic word, input logic imm_op, input logic ill);
    exp_t e;
    e.rs1     = ins[19:15];
    e.rd      = ins[11:7];
    e.illegal = ill;
    if (ill) begin
      e.rs2 = ins[24:20]; e.alu = 4'd0; e.word = 1'b0; e.use_imm = 1'b0;
      e.imm = '0; e.rd_we = 1'b0;
    end else begin
      e.rs2     = imm_op ? 5'd0 : ins[24:20];
      e.alu     = alu;
      e.word    = word;
      e.use_imm = imm_op;
      e.imm     = imm_op ? {{(XLEN-12){ins[31]}}, ins[31:20]} : '0;
      e.rd_we   = (ins[11:7] != 5'd0);
    end
    return e;
  endfunction

  task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                      input logic rdy, input exp_t e);
    logic acc;
    @(negedge clk);
    in_valid = v; in_instr = ins; flush = fl; out_ready = rdy;
    #1;
    chk("in_ready", 128'(in_ready), 128'(!m_valid || rdy));
    chk("out_valid", 128'(out_valid), 128'(m_valid));
    if (m_valid && sb.size() > 0) chk("bundle", 128'(got), 128'(sb[0]));
    chk("illegal_cnt", 128'(illegal_cnt), 128'(m_cnt));
    @(posedge clk);
    acc = v && (!m_valid || rdy) && !fl;
    if (m_valid && (rdy || fl) && sb.size() > 0) void'(sb.pop_front());
    m_valid = fl ? 1'b0 : (acc ? 1'b1 : (rdy ? 1'b0 : m_valid));
    if (acc) begin
      sb.push_back(e);
      if (e.illegal && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic [3:0] alu, input logic word,
                      input logic imm_op, input logic ill);
    step(1'b1, ins, 1'b0, 1'b1, mk(ins, alu, word, imm_op, ill));
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b1, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_instr = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete(); m_valid = 1'b0; m_cnt = '0;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_bundle", 128'(got), 128'(0));
    chk("rst_cnt", 128'(illegal_cnt), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [3:0] r_alu [8];
    logic [3:0] i_alu [8];
    logic [31:0] a_ins, b_ins;
    r_alu = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    i_alu = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    do_reset();

    // add / sub / subw / addi from the basic checklist
    send(32'h0020_81B3, 4'd0, 1'b0, 1'b0, 1'b0);
    send(32'h4020_81B3, 4'd1, 1'b0, 1'b0, 1'b0);
    send(32'h4020_81BB, 4'd1, 1'b1, 1'b0, 1'b0);
    send(32'hFFF0_0293, 4'd0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("addi_imm_ones", 128'(out_imm), 128'({XLEN{1'b1}}));

    // every OP funct3 and OP-IMM funct3 except the shifts
    for (int f = 0; f < 8; f++)
      send(rtype(7'd0, 5'd7, 5'd6, 3'(f), 5'd9, OP), r_alu[f], 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 8; f++)
      if (f != 1 && f != 5)
        send(itype(12'h7F3, 5'd4, 3'(f), 5'd10, OPI), i_alu[f], 1'b0, 1'b1, 1'b0);

    // shift-immediate shape checks and W forms
    send(itype(12'h03F, 5'd2, 3'b001, 5'd1, OPI), 4'd2, 1'b0, 1'b1, 1'b0);
    send(itype(12'h43F, 5'd2, 3'b101, 5'd1, OPI), 4'd7, 1'b0, 1'b1, 1'b0);
    send(itype(12'h021, 5'd2, 3'b101, 5'd1, OPI), 4'd6, 1'b0, 1'b1, 1'b0);
    send(itype(12'h800, 5'd2, 3'b001, 5'd1, OPI), 4'd0, 1'b0, 1'b0, 1'b1);
    send(itype(12'h200, 5'd2, 3'b101, 5'd1, OPI), 4'd0, 1'b0, 1'b0, 1'b1);
    send(itype(12'hFFB, 5'd3, 3'b000, 5'd4, OPI32), 4'd0, 1'b1, 1'b1, 1'b0);
    send(itype(12'h01F, 5'd3, 3'b001, 5'd4, OPI32), 4'd2, 1'b1, 1'b1, 1'b0);
    send(itype(12'h020, 5'd3, 3'b001, 5'd4, OPI32), 4'd0, 1'b0, 1'b0, 1'b1);
    send(itype(12'h405, 5'd3, 3'b101, 5'd4, OPI32), 4'd7, 1'b1, 1'b1, 1'b0);
    send(rtype(7'd0, 5'd5, 5'd3, 3'b001, 5'd4, OP32), 4'd2, 1'b1, 1'b0, 1'b0);
    send(rtype(7'd0, 5'd5, 5'd3, 3'b010, 5'd4, OP32), 4'd0, 1'b0, 1'b0, 1'b1);
    send(rtype(7'h20, 5'd5, 5'd3, 3'b001, 5'd4, OP), 4'd0, 1'b0, 1'b0, 1'b1);
    send(rtype(7'd0, 5'd5, 5'd3, 3'b000, 5'd0, OP), 4'd0, 1'b0, 1'b0, 1'b0);
    send(ILL, 4'd0, 1'b0, 1'b0, 1'b1);
    idle();

    // stall: held bundle stays put and the waiting instruction is taken exactly once
    a_ins = rtype(7'd0, 5'd11, 5'd12, 3'b100, 5'd13, OP);
    b_ins = rtype(7'd0, 5'd14, 5'd15, 3'b110, 5'd16, OP);
    send(a_ins, 4'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, b_ins, 1'b0, 1'b0, mk(b_ins, 4'd8, 1'b0, 1'b0, 1'b0));
    step(1'b1, b_ins, 1'b0, 1'b1, mk(b_ins, 4'd8, 1'b0, 1'b0, 1'b0));
    idle();
    idle();

    // flush drops both the held bundle and an illegal input without counting it
    send(a_ins, 4'd5, 1'b0, 1'b0, 1'b0);
    step(1'b1, ILL, 1'b1, 1'b0, mk(ILL, 4'd0, 1'b0, 1'b0, 1'b1));
    idle();
    step(1'b1, ILL, 1'b1, 1'b1, mk(ILL, 4'd0, 1'b0, 1'b0, 1'b1));
    idle();

    // counter saturation
    for (int i = 0; i < (1 << CNT_W) + 2; i++) send(ILL, 4'd0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("cnt_saturated", 128'(illegal_cnt), 128'({CNT_W{1'b1}}));

    // reset mid-stream, then normal operation resumes
    send(ILL, 4'd0, 1'b0, 1'b0, 1'b1);
    do_reset();
    send(32'h0020_81B3, 4'd0, 1'b0, 1'b0, 1'b0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
